// File: rtl/snake_pkg.sv
// Shared snake datapath definitions: direction encoding and helpers.
package snake_pkg;

    typedef logic [1:0] dir_t;

    localparam dir_t DIR_UP    = 2'b00;
    localparam dir_t DIR_RIGHT = 2'b01;
    localparam dir_t DIR_DOWN  = 2'b10;
    localparam dir_t DIR_LEFT  = 2'b11;

    // The encoding places opposing directions two apart, so flipping the MSB reverses.
    function automatic dir_t opposite(dir_t d);
        return d ^ 2'b10;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser, stability-counter debounce and rising-edge press pulse
// for one active-high push-button.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned CNT_W           = 18
) (
    input  logic clk,
    input  logic reset_pix,
    input  logic btn_i,
    output logic press_o
);

    localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync2_q;
    logic             deb_q, deb_d;
    logic             deb_prev_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        deb_d = deb_q;
        if (sync2_q != deb_q) begin
            if (cnt_q == CntLast) begin
                deb_d = sync2_q;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset_pix) begin
        if (reset_pix) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            cnt_q      <= '0;
            deb_q      <= 1'b0;
            deb_prev_q <= 1'b0;
        end else begin
            sync1_q    <= btn_i;
            sync2_q    <= sync1_q;
            cnt_q      <= cnt_d;
            deb_q      <= deb_d;
            deb_prev_q <= deb_q;
        end
    end

    assign press_o = deb_q & ~deb_prev_q;

endmodule

// File: rtl/turn_queue.sv
// Button-to-direction input stage: debounced presses are filtered for reversals and
// no-op turns, queued, and applied one per game tick.
module turn_queue
    import snake_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned DEPTH           = 2,
    parameter int unsigned CNT_W           = 18
) (
    input  logic       clk,
    input  logic       reset_pix,
    input  logic       btn_u,
    input  logic       btn_d,
    input  logic       btn_l,
    input  logic       btn_r,
    input  logic       tick,
    output logic [1:0] dir,
    output logic [1:0] q_count,
    output logic       overflow
);

    localparam logic [1:0] PtrLast = 2'(DEPTH - 1);
    localparam logic [1:0] CntMax  = 2'(DEPTH);

    logic [3:0] raw_btn;
    logic [3:0] press;

    assign raw_btn = {btn_r, btn_l, btn_d, btn_u};

    for (genvar i = 0; i < 4; i++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_btn_debounce (
            .clk       (clk),
            .reset_pix (reset_pix),
            .btn_i     (raw_btn[i]),
            .press_o   (press[i])
        );
    end

    function automatic logic [1:0] ptr_inc(logic [1:0] p);
        return (p == PtrLast) ? 2'd0 : p + 2'd1;
    endfunction

    function automatic logic [1:0] ptr_dec(logic [1:0] p);
        return (p == 2'd0) ? PtrLast : p - 2'd1;
    endfunction

    // Storage is sized for the largest legal depth so 2-bit pointers index it exactly.
    dir_t       mem_q [4];
    dir_t       dir_q, dir_d;
    logic [1:0] head_q, head_d;
    logic [1:0] tail_q, tail_d;
    logic [1:0] count_q, count_d;
    logic       overflow_q, overflow_d;

    logic req_valid, accept, push, pop;
    dir_t req_dir, ref_dir;

    always_comb begin
        req_valid = 1'b1;
        req_dir   = DIR_UP;
        if (press[0]) begin
            req_dir = DIR_UP;
        end else if (press[1]) begin
            req_dir = DIR_DOWN;
        end else if (press[2]) begin
            req_dir = DIR_LEFT;
        end else if (press[3]) begin
            req_dir = DIR_RIGHT;
        end else begin
            req_valid = 1'b0;
        end

        // Compare against the last queued turn so chained presses stay legal relative
        // to each other, not to the direction still on screen.
        ref_dir = (count_q != 2'd0) ? mem_q[ptr_dec(tail_q)] : dir_q;
        accept  = req_valid && (req_dir != ref_dir) && (req_dir != opposite(ref_dir));
        pop     = tick && (count_q != 2'd0);
        push    = accept && ((count_q < CntMax) || pop);

        overflow_d = accept && !push;
        dir_d      = pop ? mem_q[head_q] : dir_q;
        head_d     = pop ? ptr_inc(head_q) : head_q;
        tail_d     = push ? ptr_inc(tail_q) : tail_q;
        count_d    = count_q;
        if (push && !pop) begin
            count_d = count_q + 2'd1;
        end else if (pop && !push) begin
            count_d = count_q - 2'd1;
        end
    end

    always_ff @(posedge clk or posedge reset_pix) begin
        if (reset_pix) begin
            for (int i = 0; i < 4; i++) begin
                mem_q[i] <= DIR_UP;
            end
            dir_q      <= DIR_RIGHT;
            head_q     <= 2'd0;
            tail_q     <= 2'd0;
            count_q    <= 2'd0;
            overflow_q <= 1'b0;
        end else begin
            if (push) begin
                mem_q[tail_q] <= req_dir;
            end
            dir_q      <= dir_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    assign dir      = dir_q;
    assign q_count  = count_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_turn_queue.sv
// Directed bench for turn_queue with a short debounce window and a two-entry queue.
module tb_turn_queue;

    logic       clk = 1'b0;
    logic       reset_pix = 1'b1;
    logic [3:0] btn = 4'b0000;  // {r, l, d, u}
    logic       tick = 1'b0;
    logic [1:0] dir;
    logic [1:0] q_count;
    logic       overflow;

    int checks = 0;
    int errors = 0;
    int ovf_cnt = 0;

    localparam logic [3:0] BU = 4'b0001;
    localparam logic [3:0] BD = 4'b0010;
    localparam logic [3:0] BL = 4'b0100;
    localparam logic [3:0] BR = 4'b1000;

    turn_queue #(
        .DEBOUNCE_CYCLES (4),
        .DEPTH           (2),
        .CNT_W           (3)
    ) dut (
        .clk       (clk),
        .reset_pix (reset_pix),
        .btn_u     (btn[0]),
        .btn_d     (btn[1]),
        .btn_l     (btn[2]),
        .btn_r     (btn[3]),
        .tick      (tick),
        .dir       (dir),
        .q_count   (q_count),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (overflow === 1'b1) ovf_cnt++;
    end

    task automatic do_reset();
        @(negedge clk);
        reset_pix = 1'b1;
        @(negedge clk);
        reset_pix = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic press(input logic [3:0] m);
        btn = m;
        repeat (10) @(negedge clk);
        btn = 4'b0000;
        repeat (10) @(negedge clk);
    endtask

    task automatic do_tick();
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
    endtask

    task automatic expect_state(input string name, input logic [1:0] exp_dir,
                                input logic [1:0] exp_cnt);
        checks++;
        if (dir !== exp_dir) begin
            $display("FAIL %s dir: got %b expected %b", name, dir, exp_dir);
            errors++;
        end
        checks++;
        if (q_count !== exp_cnt) begin
            $display("FAIL %s q_count: got %0d expected %0d", name, q_count, exp_cnt);
            errors++;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        expect_state("reset_init", 2'b01, 2'd0);
        checks++;
        if (overflow !== 1'b0) begin
            $display("FAIL reset_init overflow: got %b expected 0", overflow);
            errors++;
        end
        reset_pix = 1'b0;
        repeat (2) @(negedge clk);
        press(BU);
        expect_state("reset_prequeue", 2'b01, 2'd1);
        // Hold up through an asynchronous mid-cycle reset.
        btn = BU;
        repeat (3) @(negedge clk);
        #2 reset_pix = 1'b1;
        #1;
        expect_state("reset_async", 2'b01, 2'd0);
        checks++;
        if (overflow !== 1'b0) begin
            $display("FAIL reset_async overflow: got %b expected 0", overflow);
            errors++;
        end
        @(negedge clk);
        reset_pix = 1'b0;
        repeat (6) @(negedge clk);
        expect_state("reset_held_early", 2'b01, 2'd0);
        @(negedge clk);
        expect_state("reset_held_push", 2'b01, 2'd1);
        repeat (15) @(negedge clk);
        expect_state("reset_held_once", 2'b01, 2'd1);
        btn = 4'b0000;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_bounce();
        do_reset();
        for (int i = 0; i < 40; i++) begin
            btn = ((i / 3) % 2 == 0) ? BU : 4'b0000;
            @(negedge clk);
        end
        btn = 4'b0000;
        repeat (10) @(negedge clk);
        expect_state("bounce_none", 2'b01, 2'd0);
        btn = BU;
        repeat (6) @(negedge clk);
        btn = 4'b0000;
        repeat (15) @(negedge clk);
        expect_state("bounce_hold", 2'b01, 2'd1);
    endtask

    task automatic test_two_turn();
        do_reset();
        press(BU);
        press(BL);
        expect_state("two_queued", 2'b01, 2'd2);
        do_tick();
        expect_state("two_tick1", 2'b00, 2'd1);
        do_tick();
        expect_state("two_tick2", 2'b11, 2'd0);
        do_tick();
        expect_state("two_tick3", 2'b11, 2'd0);
    endtask

    task automatic test_reject();
        int base;
        do_reset();
        base = ovf_cnt;
        press(BL);
        expect_state("reject_reverse", 2'b01, 2'd0);
        press(BR);
        expect_state("reject_same", 2'b01, 2'd0);
        press(BU);
        expect_state("reject_accept_u", 2'b01, 2'd1);
        press(BD);
        expect_state("reject_tail_rev", 2'b01, 2'd1);
        checks++;
        if (ovf_cnt - base != 0) begin
            $display("FAIL reject_overflow: got %0d pulses expected 0", ovf_cnt - base);
            errors++;
        end
    endtask

    task automatic test_overflow();
        int base;
        do_reset();
        press(BU);
        press(BL);
        base = ovf_cnt;
        press(BD);
        expect_state("ovf_drop", 2'b01, 2'd2);
        checks++;
        if (ovf_cnt - base != 1) begin
            $display("FAIL ovf_pulse: got %0d cycles expected 1", ovf_cnt - base);
            errors++;
        end
        // Line the tick up with the press pulse: raw high, 6 edges, then the pulse edge.
        btn = BD;
        repeat (6) @(negedge clk);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        expect_state("ovf_concurrent", 2'b00, 2'd2);
        btn = 4'b0000;
        repeat (10) @(negedge clk);
        checks++;
        if (ovf_cnt - base != 1) begin
            $display("FAIL ovf_concurrent_pulse: got %0d cycles expected 1", ovf_cnt - base);
            errors++;
        end
        do_tick();
        expect_state("ovf_drain_l", 2'b11, 2'd1);
        do_tick();
        expect_state("ovf_drain_d", 2'b10, 2'd0);
    endtask

    task automatic test_simultaneous();
        do_reset();
        press(BU | BD);
        expect_state("simul_one", 2'b01, 2'd1);
        do_tick();
        expect_state("simul_up", 2'b00, 2'd0);
    endtask

    initial begin
        test_reset();
        test_bounce();
        test_two_turn();
        test_reject();
        test_overflow();
        test_simultaneous();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/turn_queue.md
# turn_queue

Upstream input stage for the snake datapath. Turns four raw push-buttons into a registered 2-bit direction for the head/collision logic, clocked on the 25 MHz pixel clock. It synchronises and debounces each button, edge-detects presses, and rejects reversals and no-op turns. Accepted turns go into a small FIFO, and exactly one queued turn is applied per game tick, so two quick presses between ticks (e.g. up then left) both take effect.

## Interface
- `DEBOUNCE_CYCLES`, default 250000: consecutive stable synchronised samples needed to change a debounced level (10 ms at 25 MHz).
- `DEPTH`, default 2: turn FIFO depth. Legal values are 1..3.
- `CNT_W`, default 18: debounce counter width. Must satisfy 2^CNT_W > DEBOUNCE_CYCLES.
- `clk` in 1: pixel clock, 25 MHz.
- `reset_pix` in 1: asynchronous, active-high reset. Clock is `clk`.
- `btn_u`, `btn_d`, `btn_l`, `btn_r` in 1 each: raw asynchronous buttons, active-high.
- `tick` in 1: one-cycle game tick, already gated by game-over.
- `dir` out 2: current direction. 00=up, 01=right, 10=down, 11=left.
- `q_count` out 2: number of queued turns, 0..DEPTH.
- `overflow` out 1: one-cycle pulse when a valid turn is dropped because the FIFO is full.

## Operation
- **Synchroniser:** 2-FF per button.
- **Debounce:** per button, a counter runs while the synchronised level differs from the debounced level. It clears when the levels match. When it reaches DEBOUNCE_CYCLES-1, the debounced level takes the synchronised value and the counter clears.
- **Press detection:** a press is a debounced 0→1 transition, producing a 1-cycle pulse. Releases generate nothing.
- **Simultaneous presses:** accept at most one per cycle, priority U > D > L > R. Lower-priority presses in that cycle are discarded, not deferred.
- **Reference direction:** the FIFO tail entry if `q_count` > 0, otherwise `dir`. The pre-pop value is used even if `tick` pops in the same cycle.
- **Rejection:** reject the request if it equals the reference, or equals the reference XOR 2'b10 (a reversal). Rejected presses do not pulse `overflow`.
- **Push:** a valid request is pushed if `q_count` < DEPTH, or if `tick` pops in the same cycle. Otherwise it is dropped and `overflow` pulses.
- **Tick with non-empty FIFO:** `dir` takes the head entry and the FIFO pops. Push and pop in one cycle leave `q_count` unchanged.
- **Tick with empty FIFO:** `dir` holds.
- **Reset values:** `dir`=01 (right), `q_count`=0, `overflow`=0, debounced levels=0, counters=0, synchroniser FFs=0.
- **Button held through reset:** the debounced level is cleared to 0 by reset. After release of reset plus sync and debounce latency, the held button generates exactly one press, which is subject to normal rejection.

## Timing
- **Raw edge to press pulse:** 2 sync cycles + DEBOUNCE_CYCLES + 1 cycle, with the raw level held stable.
- **Press pulse to FIFO:** the FIFO updates at the same clock edge as the pulse. `q_count` is visible the next cycle.
- **`tick` to `dir`:** `dir` updates at the edge where `tick`=1 and is visible the following cycle. This is the same edge at which the downstream head register samples.
- **Latency guarantee:** a turn pushed in cycle N is never applied before the first tick at cycle > N.
- **Glitches:** any glitch shorter than DEBOUNCE_CYCLES restarts the counter and produces no press.
- **Overflow:** `overflow` is registered, one cycle wide, and asserted in the cycle after the dropped press.

## Structure
- **Shared package (`snake_pkg`):** `DIR_UP`/`DIR_RIGHT`/`DIR_DOWN`/`DIR_LEFT` constants, a 2-bit direction type, and an `opposite()` function (XOR 2'b10). `snake_head` and `top` use the same package.
- **Sub-module:** `btn_debounce` (sync + counter + rising-edge pulse), instantiated four times.
- **FIFO:** circular buffer with head/tail pointers and a count, inline in `turn_queue`.

## Test plan
All scenarios run with `DEBOUNCE_CYCLES`=4 and `DEPTH`=2.
- **Reset:** assert `reset_pix` mid-run with 1 item queued → immediately `dir`=01, `q_count`=0, `overflow`=0. Hold `btn_u` through reset → exactly one up push appears 2+4+1 cycles after release.
- **Bounce:** toggle `btn_u` with 3-cycle pulses for 40 cycles → no push, `q_count`=0. Then hold for 6 cycles → exactly one push.
- **Two-turn queue:** from `dir`=01, press U, then L, with no tick → `q_count`=2. Tick → `dir`=00, `q_count`=1. Tick → `dir`=11, `q_count`=0. Tick → `dir`=11.
- **Rejection:** `dir`=01, press L → rejected. Press R → rejected. Queue U, then press D → rejected (reference is the U tail). `q_count` stays 1 and `overflow` stays 0 throughout.
- **Overflow and concurrency:** queue U,L. Press D with no tick → dropped, `overflow` pulses once, `q_count`=2. Press D coincident with `tick` → `dir`=00, queue becomes L,D, `q_count`=2.
- **Simultaneous buttons:** from `dir`=01, U and D debounced in the same cycle → only U pushed.
